// File: rtl/cpa_pkg.sv
// Shared widths and the per-stage pipeline bundle for the
// segmented final carry-propagate adder.
package cpa_pkg;

    localparam int CPA_WIDTH  = 64;
    localparam int CPA_SEG    = 16;
    localparam int CPA_STAGES = CPA_WIDTH / CPA_SEG;

    typedef logic [CPA_SEG-1:0] cpa_seg_t;

    // sum holds resolved lower segments and untouched upper ones
    typedef struct packed {
        logic                 valid;
        logic [CPA_WIDTH-1:0] sum;
        logic [CPA_WIDTH-1:0] carry;
        logic                 cin;
    } cpa_stage_t;

endpackage

// File: rtl/cpa_seg_stage.sv
// One segment of the carry-propagate adder: segment add,
// pipeline register and stage-advance logic.
module cpa_seg_stage
    import cpa_pkg::*;
#(
    parameter int K = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  cpa_stage_t prev,
    input  logic       next_ready,
    output logic       ready,
    output cpa_stage_t cur
);

    localparam int LO = K * CPA_SEG;

    logic [CPA_SEG:0] add;
    cpa_seg_t         sa;
    cpa_seg_t         ca;
    cpa_stage_t       nxt;

    assign sa    = prev.sum[LO +: CPA_SEG];
    assign ca    = prev.carry[LO +: CPA_SEG];
    assign add   = {1'b0, sa} + {1'b0, ca} + {{CPA_SEG{1'b0}}, prev.cin};
    assign ready = !cur.valid || next_ready;

    always_comb begin
        nxt                    = prev;
        nxt.sum[LO +: CPA_SEG] = add[CPA_SEG-1:0];
        nxt.cin                = add[CPA_SEG];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (ready) begin
            if (prev.valid) begin
                cur <= nxt;
            end else begin
                cur.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csa_final_adder_pipe.sv
// Pipelined final adder resolving the Wallace-tree sum/carry pair.
// CPA_SKID_EN adds a 2-entry output skid buffer that cuts out_ready->in_ready.
module csa_final_adder_pipe
    import cpa_pkg::*;
#(
    parameter int WIDTH = CPA_WIDTH,
    parameter int SEG   = CPA_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product
);

    localparam int STAGES = WIDTH / SEG;

    cpa_stage_t        stg [0:STAGES];
    logic [STAGES:0]   rdy;
    cpa_stage_t        tail;
    logic              unused_tail;

    assign stg[0]      = '{valid: in_valid, sum: in_sum, carry: in_carry, cin: 1'b0};
    assign in_ready    = rdy[0] && !rst;
    assign tail        = stg[STAGES];
    assign unused_tail = ^{tail.carry, tail.cin};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cpa_seg_stage #(
            .K(k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .prev      (stg[k]),
            .next_ready(rdy[k+1]),
            .ready     (rdy[k]),
            .cur       (stg[k+1])
        );
    end

`ifdef CPA_SKID_EN
    logic [WIDTH-1:0] mem [0:1];
    logic [1:0]       cnt;
    logic             wp;
    logic             rp;
    logic             push;
    logic             pop;

    // tail bypasses the buffer when empty so latency is unchanged
    assign rdy[STAGES] = (cnt != 2'd2);
    assign pop         = (cnt != 2'd0) && out_ready;
    assign push        = tail.valid && rdy[STAGES] && !((cnt == 2'd0) && out_ready);
    assign out_valid   = (cnt != 2'd0) || tail.valid;
    assign out_product = (cnt != 2'd0) ? mem[rp] : tail.sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            wp  <= 1'b0;
            rp  <= 1'b0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= tail.sum;
        end
    end
`else
    assign rdy[STAGES] = out_ready;
    assign out_valid   = tail.valid;
    assign out_product = tail.sum;
`endif

endmodule
